// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC select encoding and ras_err bit positions shared by pc_unit.
package pc_unit_pkg;
  typedef enum logic [1:0] {SEL_PEND, SEL_REDIR, SEL_RET, SEL_SEQ} sel_t;
  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow,
  output logic         underflow
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW:0] cnt;
  logic do_pop;
  assign empty     = cnt == '0;
  assign full      = cnt == (PW+1)'(DEPTH);
  assign do_pop    = pop & ~push & ~empty;
  assign top       = mem[wp - PW'(1)];
  assign overflow  = push & full;
  assign underflow = pop & ~push & empty;
  // When full, wp already points at the oldest slot, so wrapping overwrites it.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (push) begin
      wp  <= wp + PW'(1);
      cnt <= full ? cnt : cnt + 1'b1;
    end else if (do_pop) begin
      wp  <= wp - PW'(1);
      cnt <= cnt - 1'b1;
    end
  end
  always_ff @(negedge clk) begin
    if (push) mem[wp] <= push_data;
  end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: falling-edge program counter with stall, pending redirect and optional RAS.
// Define PC_UNIT_RAS_EN to build the return-address stack (call/ret support).
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int          ADDR_W    = 18,
  parameter int          STEP      = 1,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc_out,
  output logic              ras_empty,
  output logic              ras_full,
  output logic [1:0]        ras_err
);
  logic [ADDR_W-1:0] seq, pend_tgt, ras_top, next_pc;
  logic pend, push, pop, ret_hit, ovf, udf;
  sel_t sel;
  assign seq  = pc_out + ADDR_W'(STEP);
  assign push = pc_write & redirect_valid & call;
  assign pop  = pc_write & ret & ~redirect_valid;
`ifdef PC_UNIT_RAS_EN
  pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ovf),
    .underflow (udf)
  );
`else
  assign ras_top   = '0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ovf       = push & ras_full;
  assign udf       = pop & ras_full;
`endif
  assign ret_hit = pop & ~ras_empty;
  // A live redirect wins over a pending one and retires it on the same edge.
  always_comb begin
    sel     = redirect_valid ? SEL_REDIR : pend ? SEL_PEND : ret_hit ? SEL_RET : SEL_SEQ;
    next_pc = sel == SEL_REDIR ? redirect_target :
              sel == SEL_PEND  ? pend_tgt :
              sel == SEL_RET   ? ras_top : seq;
  end
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pc_out   <= RESET_VEC;
      pend     <= 1'b0;
      pend_tgt <= '0;
      ras_err  <= '0;
    end else begin
      if (pc_write) pc_out <= next_pc;
      if (!pc_write && redirect_valid) begin
        pend     <= 1'b1;
        pend_tgt <= redirect_target;
      end else if (pc_write) begin
        pend <= 1'b0;
      end
      if (ovf) ras_err[ERR_OVF] <= 1'b1;
      if (udf) ras_err[ERR_UDF] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed table plus hand sequences for stall, reset, call/ret and RAS overflow.
module tb_pc_unit;
  logic clk = 1'b0, rst = 1'b1, pc_write = 1'b0, redirect_valid = 1'b0, call = 1'b0, ret = 1'b0;
  logic [17:0] redirect_target = '0;
  logic [17:0] pc_out;
  logic ras_empty, ras_full;
  logic [1:0] ras_err;
  int n_vec = 0, n_bad = 0;

  pc_unit #(.ADDR_W(18), .STEP(1), .RESET_VEC(18'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .call(call), .ret(ret), .pc_out(pc_out),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic pw, rv;
    logic [17:0] tgt;
    logic cl, rt;
    logic [17:0] pc;
  } vec_t;
  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic rv, input logic [17:0] tgt, input logic cl, input logic rt);
    pc_write = pw; redirect_valid = rv; redirect_target = tgt; call = cl; ret = rt;
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00001};
    vt[1]  = '{1'b1, 1'b1, 18'h3FFFE, 1'b0, 1'b0, 18'h3FFFE};
    vt[2]  = '{1'b1, 1'b0, 18'h0,     1'b0, 1'b0, 18'h3FFFF};
    vt[3]  = '{1'b1, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00000};
    vt[4]  = '{1'b1, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00001};
    vt[5]  = '{1'b0, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00001};
    vt[6]  = '{1'b1, 1'b1, 18'h00020, 1'b0, 1'b0, 18'h00020};
    vt[7]  = '{1'b0, 1'b1, 18'h00100, 1'b0, 1'b0, 18'h00020};
    vt[8]  = '{1'b0, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00020};
    vt[9]  = '{1'b0, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00020};
    vt[10] = '{1'b1, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00100};
    vt[11] = '{1'b1, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00101};
    vt[12] = '{1'b0, 1'b1, 18'h00300, 1'b0, 1'b0, 18'h00101};
    vt[13] = '{1'b0, 1'b1, 18'h00400, 1'b0, 1'b0, 18'h00101};
    vt[14] = '{1'b1, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00400};
    vt[15] = '{1'b0, 1'b1, 18'h00500, 1'b1, 1'b0, 18'h00400};
    vt[16] = '{1'b1, 1'b0, 18'h0,     1'b0, 1'b0, 18'h00500};
    vt[17] = '{1'b1, 1'b1, 18'h00600, 1'b0, 1'b1, 18'h00600};

    #2;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_empty", ras_empty, 1);
    chk("reset_full", ras_full, 0);
    chk("reset_err", ras_err, 0);
    rst = 1'b0;
    @(posedge clk);

    // Wrap, stall hold, pending redirect capture/overwrite and stalled call are table-driven.
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].pw, vt[i].rv, vt[i].tgt, vt[i].cl, vt[i].rt);
      chk($sformatf("vec%0d_pc", i), pc_out, vt[i].pc);
      chk($sformatf("vec%0d_empty", i), ras_empty, 1);
      chk($sformatf("vec%0d_err", i), ras_err, 0);
    end

    // Mid-cycle reset with a redirect pending.
    drive(1'b1, 1'b1, 18'h00010, 1'b0, 1'b0);
    chk("pre_rst_pc", pc_out, 32'h10);
    drive(1'b0, 1'b1, 18'h00080, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc_out, 32'h0);
    chk("async_rst_empty", ras_empty, 1);
    chk("async_rst_err", ras_err, 0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 18'h0, 1'b0, 1'b0);
    chk("rst_drops_pend", pc_out, 32'h1);

    // Call then ret.
    drive(1'b1, 1'b1, 18'h00050, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 18'h00200, 1'b1, 1'b0);
    chk("call_pc", pc_out, 32'h200);
`ifdef PC_UNIT_RAS_EN
    chk("call_nonempty", ras_empty, 0);
`else
    chk("call_empty_tied", ras_empty, 1);
`endif
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 18'h0, 1'b0, 1'b0);
    chk("pre_ret_pc", pc_out, 32'h203);
    drive(1'b1, 1'b0, 18'h0, 1'b0, 1'b1);
`ifdef PC_UNIT_RAS_EN
    chk("ret_pc", pc_out, 32'h51);
`else
    chk("ret_pc", pc_out, 32'h204);
`endif
    chk("ret_empty", ras_empty, 1);
    chk("ret_err", ras_err, 0);

`ifdef PC_UNIT_RAS_EN
    // Five calls into a 4-deep stack, then five returns.
    do_reset();
    drive(1'b1, 1'b1, 18'h00010, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 18'(i * 256), 1'b1, 1'b0);
      chk($sformatf("call%0d_pc", i), pc_out, i * 256);
      chk($sformatf("call%0d_full", i), ras_full, i >= 4);
      chk($sformatf("call%0d_err", i), ras_err, i == 5 ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 18'h0, 1'b0, 1'b1);
      chk($sformatf("ret%0d_pc", i + 1), pc_out, 32'h401 - 32'(i * 256));
    end
    chk("ret4_empty", ras_empty, 1);
    drive(1'b1, 1'b0, 18'h0, 1'b0, 1'b1);
    chk("ret5_pc", pc_out, 32'h102);
    chk("ret5_err", ras_err, 3);
    drive(1'b1, 1'b0, 18'h0, 1'b0, 1'b0);
    chk("err_sticky", ras_err, 3);
    do_reset();
    chk("err_cleared", ras_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
